// File: rtl/losc_ctrl_pkg.sv
// Shared definitions for the low-speed oscillator controller.
// State encoding, parameter defaults and counter widths.
package losc_ctrl_pkg;

    localparam int unsigned TRIM_W = 5;
    localparam int unsigned ECNT_W = 3;
    localparam int unsigned TMO_W  = 13;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int unsigned STAB_EDGES_DEF = 4;
    localparam int unsigned STOP_EDGES_DEF = 2;
    localparam int unsigned TMO_CYC_DEF    = 4096;
    localparam logic [TRIM_W-1:0] TRIM_RST_DEF = 5'h10;

    typedef logic [TRIM_W-1:0] trim_t;

    function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/losc_edge_sync.sv
// Three-flop synchroniser for an asynchronous clock-monitor input.
// Rise/fall are single-cycle pulses taken from the last two flops.
module losc_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [2:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], i_async};
        end
    end

    assign o_rise = r_sync[1] & ~r_sync[2];
    assign o_fall = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/losc_ctrl.sv
// LOSC run/stop sequencer: merges WDT/timer requests, waits for
// stable edges on start, drains edges on stop, and owns the trim.
module losc_ctrl
    import losc_ctrl_pkg::*;
#(
    parameter int unsigned STAB_EDGES = STAB_EDGES_DEF,
    parameter int unsigned STOP_EDGES = STOP_EDGES_DEF,
    parameter int unsigned TMO_CYC    = TMO_CYC_DEF,
    parameter logic [TRIM_W-1:0] TRIM_RST = TRIM_RST_DEF
) (
    input  logic              CLK30MHZ,
    input  logic              PONRESB,
    input  logic              WDTREQ,
    input  logic              TMRREQ,
    input  logic              FORCEON,
    input  logic              CPURCLK3,
    input  logic              TRIMWE,
    input  logic [TRIM_W-1:0] TRIMD,
    input  logic              ERRCLR,
    output logic              LOSCSTPZ,
    output logic              LOSCRDY,
    output logic              WDTACK,
    output logic              TMRACK,
    output logic              LOSCBUSY,
    output logic              LOSCERR,
    output logic [TRIM_W-1:0] FRSEL
);

    localparam logic [ECNT_W-1:0] LP_STAB = ECNT_W'(STAB_EDGES);
    localparam logic [ECNT_W-1:0] LP_STOP = ECNT_W'(STOP_EDGES);
    localparam logic [TMO_W-1:0]  LP_TMO  = TMO_W'(TMO_CYC);

    logic              w_rise;
    logic              w_fall;
    logic              w_wreq;
    logic              w_treq;
    logic              w_req;
    logic              w_entry;
    logic              w_tmo_hit;
    logic              w_err_set;
    logic [1:0]        w_state_nxt;
    logic [ECNT_W-1:0] w_ecnt_inc;

    logic [1:0]        r_state;
    logic [ECNT_W-1:0] r_ecnt;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_err;
    logic              r_pend;
    trim_t             r_pend_val;
    trim_t             r_frsel;
    logic              r_stpz;
    logic              r_rdy;
    logic              r_busy;
    logic              r_wreq_d;
    logic              r_treq_d;
    logic              r_wack;
    logic              r_tack;

    losc_edge_sync u_sync (
        .i_clk   (CLK30MHZ),
        .i_rst_n (PONRESB),
        .i_async (CPURCLK3),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_wreq     = WDTREQ | FORCEON;
    assign w_treq     = TMRREQ;
    assign w_req      = (w_wreq | w_treq) & ~r_err;
    assign w_ecnt_inc = sat_inc(r_ecnt);
    assign w_tmo_hit  = (r_tmo == TMO_W'(1)) & ~(w_rise | w_fall);
    assign w_entry    = (w_state_nxt != r_state);

    // A pending trim holds off START so the new value reaches the macro first
    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_req && !r_pend && !TRIMWE) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (!w_req) begin
                    w_state_nxt = ST_STOP;
                end else if (w_rise && (w_ecnt_inc == LP_STAB)) begin
                    w_state_nxt = ST_RUN;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_STOP;
                    w_err_set   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_req) begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                if (w_fall && (w_ecnt_inc == LP_STOP)) begin
                    w_state_nxt = ST_OFF;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_OFF;
                    w_err_set   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK30MHZ or negedge PONRESB) begin
        if (!PONRESB) begin
            r_state <= ST_OFF;
            r_ecnt  <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_entry) begin
                r_ecnt <= '0;
            end else if ((r_state == ST_START && w_rise) ||
                         (r_state == ST_STOP && w_fall)) begin
                r_ecnt <= w_ecnt_inc;
            end
            if (w_entry || w_rise || w_fall) begin
                r_tmo <= LP_TMO;
            end else if (r_tmo != '0) begin
                r_tmo <= r_tmo - 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (ERRCLR) begin
                r_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK30MHZ or negedge PONRESB) begin
        if (!PONRESB) begin
            r_pend     <= 1'b0;
            r_pend_val <= TRIM_RST;
            r_frsel    <= TRIM_RST;
        end else if (TRIMWE) begin
            r_pend     <= 1'b1;
            r_pend_val <= TRIMD;
        end else if (r_pend && r_state == ST_OFF) begin
            r_pend  <= 1'b0;
            r_frsel <= r_pend_val;
        end
    end

    // Requests are delayed one cycle so ACKs drop together with LOSCRDY
    always_ff @(posedge CLK30MHZ or negedge PONRESB) begin
        if (!PONRESB) begin
            r_stpz   <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
            r_wreq_d <= 1'b0;
            r_treq_d <= 1'b0;
            r_wack   <= 1'b0;
            r_tack   <= 1'b0;
        end else begin
            r_stpz   <= (r_state == ST_START) | (r_state == ST_RUN);
            r_rdy    <= (r_state == ST_RUN);
            r_busy   <= (r_state == ST_START) | (r_state == ST_STOP);
            r_wreq_d <= w_wreq;
            r_treq_d <= w_treq;
            r_wack   <= r_wreq_d & (r_state == ST_RUN);
            r_tack   <= r_treq_d & (r_state == ST_RUN);
        end
    end

    assign LOSCSTPZ = r_stpz;
    assign LOSCRDY  = r_rdy;
    assign LOSCBUSY = r_busy;
    assign WDTACK   = r_wack;
    assign TMRACK   = r_tack;
    assign LOSCERR  = r_err;
    assign FRSEL    = r_frsel;

endmodule

// File: tb/tb_losc_ctrl.sv
// Directed bench for losc_ctrl: start, stop, abort, timeout,
// trim hand-off and asynchronous reset.
module tb_losc_ctrl;

    logic       CLK30MHZ;
    logic       PONRESB;
    logic       WDTREQ;
    logic       TMRREQ;
    logic       FORCEON;
    logic       CPURCLK3;
    logic       TRIMWE;
    logic [4:0] TRIMD;
    logic       ERRCLR;
    logic       LOSCSTPZ;
    logic       LOSCRDY;
    logic       WDTACK;
    logic       TMRACK;
    logic       LOSCBUSY;
    logic       LOSCERR;
    logic [4:0] FRSEL;

    int tot = 0;
    int bad = 0;
    logic losc_en = 1'b0;
    int losc_cnt = 0;

    losc_ctrl dut (
        .CLK30MHZ (CLK30MHZ),
        .PONRESB  (PONRESB),
        .WDTREQ   (WDTREQ),
        .TMRREQ   (TMRREQ),
        .FORCEON  (FORCEON),
        .CPURCLK3 (CPURCLK3),
        .TRIMWE   (TRIMWE),
        .TRIMD    (TRIMD),
        .ERRCLR   (ERRCLR),
        .LOSCSTPZ (LOSCSTPZ),
        .LOSCRDY  (LOSCRDY),
        .WDTACK   (WDTACK),
        .TMRACK   (TMRACK),
        .LOSCBUSY (LOSCBUSY),
        .LOSCERR  (LOSCERR),
        .FRSEL    (FRSEL)
    );

    initial CLK30MHZ = 1'b0;
    always #16 CLK30MHZ = ~CLK30MHZ;

    // 2000-cycle LOSC period, held low when disabled
    always @(negedge CLK30MHZ) begin
        if (!losc_en) begin
            losc_cnt = 0;
            CPURCLK3 = 1'b0;
        end else if (losc_cnt == 999) begin
            losc_cnt = 0;
            CPURCLK3 = ~CPURCLK3;
        end else begin
            losc_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK30MHZ);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return LOSCSTPZ;
            1: return LOSCRDY;
            2: return LOSCBUSY;
            default: return LOSCERR;
        endcase
    endfunction

    task automatic wait_sig(input int w, input logic v, input int lim,
                            output int n);
        n = 0;
        while (sig(w) !== v && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rises(input int cnt, input int lim, output int n);
        int seen;
        logic prev;
        seen = 0;
        n = 0;
        prev = CPURCLK3;
        while (seen < cnt && n < lim) begin
            tick();
            n++;
            if (CPURCLK3 && !prev) seen++;
            prev = CPURCLK3;
        end
    endtask

    initial begin
        int n;
        logic seen;

        PONRESB = 1'b0;
        WDTREQ  = 1'b0;
        TMRREQ  = 1'b0;
        FORCEON = 1'b0;
        TRIMWE  = 1'b0;
        TRIMD   = 5'h00;
        ERRCLR  = 1'b0;
        #100;
        chk("rst_stpz", LOSCSTPZ, 0);
        chk("rst_rdy", LOSCRDY, 0);
        chk("rst_busy", LOSCBUSY, 0);
        chk("rst_err", LOSCERR, 0);
        chk("rst_acks", {WDTACK, TMRACK}, 0);
        chk("rst_frsel", FRSEL, 5'h10);
        PONRESB = 1'b1;
        repeat (5) tick();

        // normal start
        WDTREQ = 1'b1;
        tick();
        chk("start_stpz_c1", LOSCSTPZ, 0);
        tick();
        chk("start_stpz_c2", LOSCSTPZ, 1);
        chk("start_busy", LOSCBUSY, 1);
        losc_en = 1'b1;
        wait_sig(1, 1'b1, 12000, n);
        chk("start_rdy_seen", n < 12000, 1);
        chk("start_rdy_lat", (n > 6500) && (n < 7500), 1);
        chk("start_wack", WDTACK, 1);
        chk("start_tack", TMRACK, 0);
        chk("start_busy_run", LOSCBUSY, 0);

        // stop
        WDTREQ = 1'b0;
        tick();
        chk("stop_c1", {LOSCSTPZ, LOSCRDY, WDTACK}, 3'b111);
        tick();
        chk("stop_c2", {LOSCSTPZ, LOSCRDY, WDTACK}, 3'b000);
        chk("stop_busy", LOSCBUSY, 1);
        wait_sig(2, 1'b0, 6000, n);
        chk("stop_off_seen", n < 6000, 1);
        chk("stop_off_stpz", LOSCSTPZ, 0);
        repeat (10) tick();
        chk("stop_off_idle", {LOSCBUSY, LOSCSTPZ, LOSCERR}, 3'b000);

        // abort in START and late request during STOP
        TMRREQ = 1'b1;
        wait_sig(0, 1'b1, 5, n);
        chk("abort_stpz", n < 5, 1);
        wait_rises(2, 5000, n);
        chk("abort_rises", n < 5000, 1);
        repeat (6) tick();
        chk("abort_pre_rdy", {LOSCRDY, LOSCBUSY}, 2'b01);
        TMRREQ = 1'b0;
        repeat (3) tick();
        chk("abort_stpz_low", LOSCSTPZ, 0);
        TMRREQ = 1'b1;
        seen = 1'b0;
        n = 0;
        while (LOSCBUSY !== 1'b0 && n < 6000) begin
            tick();
            n++;
            seen |= LOSCRDY;
        end
        chk("abort_off_seen", n < 6000, 1);
        chk("abort_no_rdy", seen, 0);
        wait_sig(0, 1'b1, 5, n);
        chk("abort_restart", n, 1);
        TMRREQ = 1'b0;
        repeat (3) tick();
        wait_sig(2, 1'b0, 8000, n);
        chk("abort_cleanup", n < 8000, 1);
        repeat (5) tick();

        // edge timeout
        losc_en = 1'b0;
        repeat (10) tick();
        FORCEON = 1'b1;
        wait_sig(3, 1'b1, 5000, n);
        chk("tmo_err_lat", n, 4097);
        tick();
        chk("tmo_stpz_low", LOSCSTPZ, 0);
        chk("tmo_busy_stop", LOSCBUSY, 1);
        wait_sig(2, 1'b0, 5000, n);
        chk("tmo_stop_lat", n, 4096);
        repeat (20) tick();
        chk("tmo_stays_off", {LOSCSTPZ, LOSCBUSY, LOSCERR}, 3'b001);
        ERRCLR = 1'b1;
        tick();
        ERRCLR = 1'b0;
        chk("tmo_errclr", LOSCERR, 0);
        tick();
        chk("tmo_rst_c1", LOSCSTPZ, 0);
        tick();
        chk("tmo_rst_c2", LOSCSTPZ, 1);
        FORCEON = 1'b0;
        losc_en = 1'b1;
        wait_sig(2, 1'b0, 8000, n);
        chk("tmo_cleanup", n < 8000, 1);
        repeat (5) tick();

        // trim written during RUN
        WDTREQ = 1'b1;
        wait_sig(1, 1'b1, 12000, n);
        chk("trim_run_rdy", n < 12000, 1);
        TRIMWE = 1'b1;
        TRIMD  = 5'h0A;
        tick();
        TRIMWE = 1'b0;
        repeat (5) tick();
        chk("trim_run_hold", FRSEL, 5'h10);
        WDTREQ = 1'b0;
        seen = 1'b0;
        n = 0;
        repeat (2) tick();
        while (LOSCBUSY !== 1'b0 && n < 6000) begin
            seen |= (FRSEL !== 5'h10);
            tick();
            n++;
        end
        chk("trim_off_seen", n < 6000, 1);
        chk("trim_stop_hold", seen, 0);
        chk("trim_off_apply", FRSEL, 5'h0A);

        // trim in OFF with a simultaneous request
        repeat (5) tick();
        TRIMWE = 1'b1;
        TRIMD  = 5'h05;
        TMRREQ = 1'b1;
        tick();
        TRIMWE = 1'b0;
        chk("trim_off_c1", {FRSEL, LOSCSTPZ}, {5'h0A, 1'b0});
        tick();
        chk("trim_off_c2", {FRSEL, LOSCSTPZ}, {5'h05, 1'b0});
        tick();
        chk("trim_off_c3", LOSCSTPZ, 0);
        tick();
        chk("trim_off_c4", LOSCSTPZ, 1);
        wait_sig(1, 1'b1, 12000, n);
        chk("trim_tmr_rdy", n < 12000, 1);
        chk("trim_acks", {WDTACK, TMRACK}, 2'b01);

        // asynchronous reset in RUN
        #5;
        PONRESB = 1'b0;
        #2;
        chk("arst_stpz", LOSCSTPZ, 0);
        chk("arst_rdy", LOSCRDY, 0);
        chk("arst_frsel", FRSEL, 5'h10);
        chk("arst_err_acks", {LOSCERR, WDTACK, TMRACK}, 3'b000);
        TMRREQ = 1'b0;
        #40;
        PONRESB = 1'b1;
        repeat (5) tick();
        chk("arst_idle", {LOSCSTPZ, LOSCBUSY}, 2'b00);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
